// File: rtl/frame_rect_fill.sv
// frame_rect_fill: rectangle-fill engine emitting one frame-memory write per cycle in raster order.
// Define RECT_CLIP_EN to clamp rectangles to the frame instead of suppressing off-frame pixels.
module frame_rect_fill #(
  parameter int H_PIXELS = 160,
  parameter int V_PIXELS = 120,
  parameter int ADDR_W = 15,
  parameter int COLOR_W = 24,
  parameter int COORD_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [COORD_W-1:0] cmd_x,
  input  logic [COORD_W-1:0] cmd_y,
  input  logic [COORD_W-1:0] cmd_w,
  input  logic [COORD_W-1:0] cmd_h,
  input  logic [COLOR_W-1:0] cmd_color,
  input  logic               abort,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [COLOR_W-1:0] wr_data,
  output logic               wr_en,
  output logic               busy,
  output logic               done
);
  localparam int AW1 = ADDR_W + 1;
  typedef enum logic [1:0] {IDLE, SETUP, FILL, DONE} state_t;
  state_t state, state_n;
  logic [COORD_W-1:0] x_q, y_q, w_q, h_q, w_eff, h_eff, col, row, col_n, row_n;
  logic [COLOR_W-1:0] color_q;
  logic [ADDR_W-1:0] base, base_n;
  logic [ADDR_W:0] addr_n;
  logic accept, row_end, last, en_n;
`ifdef RECT_CLIP_EN
  function automatic logic [COORD_W-1:0] clamp(input logic [COORD_W-1:0] o, s, input int lim);
    int room;
    room = lim - int'(o);
    return room <= 0 ? '0 : int'(s) > room ? COORD_W'(room) : s;
  endfunction
  assign w_eff = clamp(x_q, w_q, H_PIXELS);
  assign h_eff = clamp(y_q, h_q, V_PIXELS);
  assign en_n = state_n == FILL;
`else
  assign w_eff = w_q;
  assign h_eff = h_q;
  // off-frame pixels still take their cycle but never strobe
  assign en_n = state_n == FILL && int'(x_q) + int'(col_n) < H_PIXELS
                && int'(y_q) + int'(row_n) < V_PIXELS;
`endif
  assign accept = cmd_valid && cmd_ready;
  assign row_end = col == w_eff - COORD_W'(1);
  assign last = row_end && row == h_eff - COORD_W'(1);
  assign addr_n = AW1'(base_n) + AW1'(x_q) + AW1'(col_n);
  always_comb begin
    state_n = state;
    col_n = col;
    row_n = row;
    base_n = base;
    case (state)
      IDLE: state_n = accept ? SETUP : IDLE;
      SETUP: begin
        col_n = '0;
        row_n = '0;
        base_n = ADDR_W'(int'(y_q) * H_PIXELS);
        state_n = abort || w_eff == '0 || h_eff == '0 ? DONE : FILL;
      end
      FILL: begin
        state_n = abort || last ? DONE : FILL;
        col_n = row_end ? '0 : col + COORD_W'(1);
        row_n = row_end ? row + COORD_W'(1) : row;
        base_n = row_end ? base + ADDR_W'(H_PIXELS) : base;
      end
      default: state_n = IDLE;
    endcase
  end
  // the next pixel is computed one cycle ahead so every output is a flop
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cmd_ready <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      wr_en <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      col <= '0;
      row <= '0;
      base <= '0;
    end else begin
      state <= state_n;
      col <= col_n;
      row <= row_n;
      base <= base_n;
      cmd_ready <= state_n == IDLE;
      busy <= state_n != IDLE;
      done <= state_n == DONE;
      wr_en <= en_n;
      if (en_n) begin
        wr_addr <= addr_n[ADDR_W-1:0];
        wr_data <= color_q;
      end
      if (accept) begin
        x_q <= cmd_x;
        y_q <= cmd_y;
        w_q <= cmd_w;
        h_q <= cmd_h;
        color_q <= cmd_color;
      end
    end
  end
endmodule

// File: tb/tb_frame_rect_fill.sv
// tb_frame_rect_fill: directed and randomized fills of frame_rect_fill checked cycle by cycle
// against a pixel-level reference model of the expected write stream.
module tb_frame_rect_fill;
  localparam int H = 160;
  localparam int V = 120;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid = 1'b0;
  logic abort = 1'b0;
  logic [7:0] cmd_x = '0, cmd_y = '0, cmd_w = '0, cmd_h = '0;
  logic [23:0] cmd_color = '0;
  logic cmd_ready, wr_en, busy, done;
  logic [14:0] wr_addr;
  logic [23:0] wr_data;
  int vectors = 0;
  int errors = 0;
  logic exp_en [512];
  int exp_addr [512];

  frame_rect_fill dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_color(cmd_color),
    .abort(abort), .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ab: cycle in which abort is held high (-1 none); rs: cycle whose closing edge sees rst (0 none);
  // hold: keep cmd_valid high with junk fields while the fill runs
  task automatic run(input int x, y, w, h, input logic [23:0] c, input int ab, rs, input bit hold);
    int iw, ih, cyc, done_c, last_c;
    bit stop;
    for (int i = 0; i < 512; i++) begin
      exp_en[i] = 1'b0;
      exp_addr[i] = 0;
    end
`ifdef RECT_CLIP_EN
    iw = x >= H ? 0 : (w < H - x ? w : H - x);
    ih = y >= V ? 0 : (h < V - y ? h : V - y);
`else
    iw = w;
    ih = h;
`endif
    cyc = 2;
    stop = 1'b0;
    if (ab != 1)
      for (int r = 0; r < ih; r++)
        for (int k = 0; k < iw; k++)
          if (!stop) begin
            exp_en[cyc] = (x + k < H) && (y + r < V);
            exp_addr[cyc] = ((y + r) * H + x + k) % 32768;
            stop = cyc == ab;
            cyc++;
          end
    done_c = cyc;
    last_c = rs > 0 ? rs + 2 : done_c + 1;
    for (int t = 0; t < 20 && cmd_ready !== 1'b1; t++) @(negedge clk);
    chk("accept_ready", 32'(cmd_ready), 32'(1));
    cmd_x = 8'(x);
    cmd_y = 8'(y);
    cmd_w = 8'(w);
    cmd_h = 8'(h);
    cmd_color = c;
    cmd_valid = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= last_c; k++) begin
      if (rs > 0 && k > rs) begin
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_wr_en", 32'(wr_en), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_ready", 32'(cmd_ready), 32'(k > rs + 1));
        if (k == rs + 1) begin
          chk("rst_wr_addr", 32'(wr_addr), 32'(0));
          chk("rst_wr_data", 32'(wr_data), 32'(0));
        end
      end else begin
        chk("busy", 32'(busy), 32'(k <= done_c));
        chk("ready", 32'(cmd_ready), 32'(k > done_c));
        chk("done", 32'(done), 32'(k == done_c));
        chk("wr_en", 32'(wr_en), 32'(exp_en[k]));
        if (exp_en[k]) begin
          chk("wr_addr", 32'(wr_addr), 32'(exp_addr[k]));
          chk("wr_data", 32'(wr_data), 32'(c));
        end
      end
      cmd_valid = hold;
      if (hold) begin
        cmd_x = 8'($urandom);
        cmd_y = 8'($urandom);
        cmd_w = 8'($urandom);
        cmd_h = 8'($urandom);
        cmd_color = 24'($urandom);
      end
      abort = k == ab && k <= done_c;
      rst = k == rs;
      if (k < last_c) @(negedge clk);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_ready", 32'(cmd_ready), 32'(0));
    chk("reset_wr_en", 32'(wr_en), 32'(0));
    chk("reset_busy", 32'(busy), 32'(0));
    chk("reset_done", 32'(done), 32'(0));
    chk("reset_wr_addr", 32'(wr_addr), 32'(0));
    chk("reset_wr_data", 32'(wr_data), 32'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_ready", 32'(cmd_ready), 32'(1));
    run(2, 3, 2, 2, 24'hFF0000, -1, 0, 1'b0);
    run(7, 9, 0, 5, 24'h00FF00, -1, 0, 1'b0);
    run(158, 0, 4, 1, 24'h0000FF, -1, 0, 1'b0);
    run(5, 119, 2, 3, 24'h123456, -1, 0, 1'b0);
    run(10, 10, 10, 10, 24'hABCDEF, 6, 0, 1'b0);
    run(20, 20, 3, 3, 24'h777777, 1, 0, 1'b0);
    run(1, 1, 3, 1, 24'hC0FFEE, -1, 0, 1'b1);
    run(40, 50, 2, 2, 24'hBEEF01, -1, 0, 1'b0);
    run(0, 0, 4, 4, 24'h5A5A5A, -1, 4, 1'b0);
    run(159, 119, 1, 1, 24'h010203, -1, 0, 1'b0);
    for (int i = 0; i < 40; i++)
      run($urandom_range(0, 170), $urandom_range(0, 130), $urandom_range(0, 12),
          $urandom_range(0, 12), 24'($urandom),
          $urandom_range(0, 3) == 0 ? int'($urandom_range(1, 40)) : -1, 0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
